li_expander: RTL and testbench

//  Load-immediate expander: the encoder counterpart of imm_gen. Accepts a (rd, 32-bit constant)

---
 rtl/li_expander_if.sv | 20 ++
 rtl/li_expander.sv | 77 +++++++
 tb/tb_li_expander.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/li_expander_if.sv
// li_expander_if: request and instruction-stream handshakes of the load-immediate expander
interface li_expander_if #(parameter int XPR_LEN = 32);
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         req_rd;
  logic [XPR_LEN-1:0] req_value;
  logic               inst_valid;
  logic               inst_ready;
  logic [XPR_LEN-1:0] inst;
  logic               inst_last;
  logic               busy;
  modport master (
    output req_valid, req_rd, req_value, inst_ready,
    input  req_ready, inst_valid, inst, inst_last, busy
  );
  modport slave (
    input  req_valid, req_rd, req_value, inst_ready,
    output req_ready, inst_valid, inst, inst_last, busy
  );
endinterface

// File: rtl/li_expander.sv
// li_expander: emits the shortest LUI/ADDI sequence that loads a 32-bit constant into rd
module li_expander #(
  parameter int XPR_LEN      = 32,
  parameter bit COMPRESS_SEQ = 1
) (
  input logic          clk,
  input logic          reset,
  li_expander_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT_LUI, EMIT_ADDI} state_t;
  state_t             state, state_n;
  logic [XPR_LEN-1:0] sum, inst_n;
  logic [19:0]        hi20;
  logic [11:0]        lo12, lo_q;
  logic [4:0]         rd_q;
  logic               load, last_n;
  // +0x800 pre-compensates the sign extension ADDI applies to lo12
  assign sum            = bus.req_value + 32'h800;
  assign hi20           = sum[31:12];
  assign lo12           = bus.req_value[11:0];
  assign bus.req_ready  = state == IDLE;
  assign bus.inst_valid = state != IDLE;
  assign bus.busy       = state != IDLE;
  always_comb begin
    state_n = state;
    load    = 1'b0;
    inst_n  = '0;
    last_n  = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        load = 1'b1;
        if (bus.req_rd == 5'd0) begin
          state_n = EMIT_ADDI;
          inst_n  = 32'h0000_0013;
          last_n  = 1'b1;
        end else if (COMPRESS_SEQ && hi20 == 20'd0) begin
          state_n = EMIT_ADDI;
          inst_n  = {lo12, 5'd0, 3'b000, bus.req_rd, 7'b0010011};
          last_n  = 1'b1;
        end else begin
          state_n = EMIT_LUI;
          inst_n  = {hi20, bus.req_rd, 7'b0110111};
          last_n  = COMPRESS_SEQ && lo12 == 12'd0;
        end
      end
      EMIT_LUI: if (bus.inst_ready) begin
        state_n = bus.inst_last ? IDLE : EMIT_ADDI;
        load    = !bus.inst_last;
        inst_n  = {lo_q, rd_q, 3'b000, rd_q, 7'b0010011};
        last_n  = 1'b1;
      end
      EMIT_ADDI: if (bus.inst_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.inst      <= '0;
      bus.inst_last <= 1'b0;
      rd_q          <= '0;
      lo_q          <= '0;
    end else begin
      if (load) begin
        bus.inst      <= inst_n;
        bus.inst_last <= last_n;
      end
      if (bus.req_valid && bus.req_ready) begin
        rd_q <= bus.req_rd;
        lo_q <= lo12;
      end
    end
  end
endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander: directed table, corner sequences and random requests checked by an encode/decode model
module tb_li_expander;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  li_expander_if bus();
  li_expander dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [31:0] got_w[4];
  logic        got_l[4];
  int          got_n;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [4:0] rd, input logic [31:0] v);
    int w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_before_request", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_value = v;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_rd    = 5'($urandom);
    bus.req_value = $urandom;
  endtask

  task automatic collect(input bit bp);
    logic [31:0] prev = '0;
    bit pend = 0;
    bit done = 0;
    int cyc = 0;
    got_n = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("first_word_latency", 32'(bus.inst_valid), 32'd1);
      if (pend) begin
        chk("held_inst", bus.inst, prev);
        chk("held_valid", 32'(bus.inst_valid), 32'd1);
      end
      if (bus.inst_valid) chk("busy_flags", 32'({bus.req_ready, bus.busy}), 32'b01);
      bus.inst_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pend = bus.inst_valid && !bus.inst_ready;
      prev = bus.inst;
      if (bus.inst_valid && bus.inst_ready) begin
        if (got_n < 4) begin
          got_w[got_n] = bus.inst;
          got_l[got_n] = bus.inst_last;
        end
        got_n++;
        done = bus.inst_last || got_n >= 4;
      end
    end
    if (!done) chk("sequence_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("idle_after_last", 32'({bus.req_ready, bus.inst_valid, bus.busy}), 32'b100);
  endtask

  // Reference: expected word list from the split rule, then replay the words on a register file
  task automatic verify(input string name, input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] hi, rf[32], exp_w[2], w;
    int n;
    hi = (v + 32'h800) >> 12;
    exp_w[0] = 32'h13;
    exp_w[1] = 32'h0;
    if (rd == 0) n = 1;
    else if (hi == 0) begin
      n = 1;
      exp_w[0] = {v[11:0], 5'd0, 3'd0, rd, 7'h13};
    end else begin
      exp_w[0] = {hi[19:0], rd, 7'h37};
      exp_w[1] = {v[11:0], rd, 3'd0, rd, 7'h13};
      n = (v[11:0] == 0) ? 1 : 2;
    end
    chk($sformatf("%s_count", name), 32'(got_n), 32'(n));
    for (int i = 0; i < n && i < got_n && i < 4; i++) begin
      chk($sformatf("%s_w%0d", name, i), got_w[i], exp_w[i]);
      chk($sformatf("%s_last%0d", name, i), 32'(got_l[i]), 32'(i == n - 1));
    end
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[0] = '0;
    for (int i = 0; i < got_n && i < 4; i++) begin
      w = got_w[i];
      if (w[6:0] == 7'h37) rf[w[11:7]] = {w[31:12], 12'd0};
      else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) rf[w[11:7]] = rf[w[19:15]] + {{20{w[31]}}, w[31:20]};
      else rf[w[11:7]] = 32'hDEAD_BEEF;
      rf[0] = '0;
    end
    if (rd != 0) chk($sformatf("%s_decoded", name), rf[rd], v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [4:0]  rd;
    bus.req_valid  = 1'b0;
    bus.req_rd     = '0;
    bus.req_value  = '0;
    bus.inst_ready = 1'b0;
    tv[0] = '{5'd5,  32'h1234_5678, 2, 32'h1234_52B7, 32'h6782_8293};
    tv[1] = '{5'd1,  32'h0000_0005, 1, 32'h0050_0093, 32'h0};
    tv[2] = '{5'd2,  32'h0000_1000, 1, 32'h0000_1137, 32'h0};
    tv[3] = '{5'd10, 32'hFFFF_F800, 1, 32'h8000_0513, 32'h0};
    tv[4] = '{5'd3,  32'h0000_0000, 1, 32'h0000_0193, 32'h0};
    tv[5] = '{5'd0,  32'hCAFE_BABE, 1, 32'h0000_0013, 32'h0};
    tv[6] = '{5'd31, 32'h0000_0800, 2, 32'h0000_1FB7, 32'h800F_8F93};
    repeat (2) @(negedge clk);
    chk("reset_flags", 32'({bus.req_ready, bus.inst_valid, bus.inst_last, bus.busy}), 32'b1000);
    chk("reset_inst", bus.inst, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(tv[i].rd, tv[i].value);
      collect(1'b0);
      chk($sformatf("tv%0d_n", i), 32'(got_n), 32'(tv[i].n));
      chk($sformatf("tv%0d_w0", i), got_w[0], tv[i].w0);
      if (tv[i].n == 2) chk($sformatf("tv%0d_w1", i), got_w[1], tv[i].w1);
      verify($sformatf("tv%0d", i), tv[i].rd, tv[i].value);
    end
    // Backpressure on the LUI with stray requests, then reset during the ADDI
    bus.inst_ready = 1'b0;
    send(5'd5, 32'h1234_5678);
    repeat (3) begin
      @(negedge clk);
      chk("bp_inst", bus.inst, 32'h1234_52B7);
      chk("bp_valid", 32'(bus.inst_valid), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = 1'b1;
      bus.req_rd    = 5'd9;
      bus.req_value = $urandom;
    end
    bus.req_valid  = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_addi", bus.inst, 32'h6782_8293);
    chk("bp_addi_last", 32'(bus.inst_last), 32'd1);
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("bp_addi_held", bus.inst, 32'h6782_8293);
    reset = 1'b1;
    #1;
    chk("async_reset_flags", 32'({bus.req_ready, bus.inst_valid, bus.busy}), 32'b100);
    chk("async_reset_inst", bus.inst, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_word", 32'({bus.inst_valid, bus.req_ready}), 32'b01);
    end
    send(5'd7, 32'h0000_07FF);
    collect(1'b0);
    verify("post_reset", 5'd7, 32'h0000_07FF);
    for (int k = 0; k < 150; k++) begin
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = {{21{1'($urandom)}}, 11'($urandom)};
        2: v = {20'($urandom), 12'd0};
        default: v = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
      endcase
      send(rd, v);
      collect(1'b1);
      verify($sformatf("rnd%0d", k), rd, v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
